// File: rtl/data_break_arbiter.sv
// Round-robin arbiter that shares the CPU data-break channel among N_REQ peripheral requesters.
// Define DB_WATCHDOG_EN to add the WAIT/XFER watchdog and the sticky tmo_err flag.
module data_break_arbiter #(
    parameter int         N_REQ     = 4,
    parameter int         DB_TMO    = 255,
    parameter logic [4:0] DB1_STATE = 5'b10100,
    parameter logic [4:0] DB2_STATE = 5'b10101
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [4:0]            state,
    input  logic                  break_in_prog,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ-1:0]      req_wr,
    input  logic [15*N_REQ-1:0]   req_addr,
    input  logic [12*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]      gnt,
    output logic [11:0]           rd_data,
    output logic                  data_break,
    output logic                  to_mem,
    output logic [14:0]           dmaAddr,
    output logic [11:0]           dmaDOUT,
    input  logic [11:0]           dmaDIN,
    output logic                  tmo_err
);
    localparam int IW = $clog2(N_REQ);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_ACK} fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [IW-1:0]    win_q, win_d;
    logic [IW-1:0]    rr_q, rr_d;
    logic             db_q, db_d;
    logic             to_mem_q, to_mem_d;
    logic [14:0]      addr_q, addr_d;
    logic [11:0]      dout_q, dout_d;
    logic [11:0]      rd_q, rd_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;

    logic             hit_s;
    logic [IW-1:0]    pick_s;
    logic [14:0]      pick_addr_s;
    logic [11:0]      pick_data_s;
    logic             pick_wr_s;

`ifdef DB_WATCHDOG_EN
    localparam int TW = ($clog2(DB_TMO + 1) > 8) ? $clog2(DB_TMO + 1) : 8;
    logic [TW-1:0]    cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
    logic             tmo_hit_s;
    assign tmo_hit_s = (cnt_q == TW'(DB_TMO - 1));
`endif

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] p);
        next_ptr = (p == IW'(N_REQ - 1)) ? {IW{1'b0}} : p + IW'(1);
    endfunction

    // Round-robin pick: offset k from rr_q maps to requester i when (rr_q + k) mod N_REQ == i.
    always_comb begin
        hit_s       = 1'b0;
        pick_s      = '0;
        pick_addr_s = '0;
        pick_data_s = '0;
        pick_wr_s   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!hit_s && req[i] && (rr_q == IW'((i - k + N_REQ) % N_REQ))) begin
                    hit_s       = 1'b1;
                    pick_s      = IW'(i);
                    pick_addr_s = req_addr[i*15 +: 15];
                    pick_data_s = req_data[i*12 +: 12];
                    pick_wr_s   = req_wr[i];
                end else begin
                    hit_s = hit_s;
                end
            end
        end
    end

    // Sequencer next state and next values of every output register.
    always_comb begin
        fsm_d    = fsm_q;
        win_d    = win_q;
        rr_d     = rr_q;
        db_d     = db_q;
        to_mem_d = to_mem_q;
        addr_d   = addr_q;
        dout_d   = dout_q;
        rd_d     = rd_q;
        gnt_d    = '0;
`ifdef DB_WATCHDOG_EN
        tmo_d    = tmo_q;
`endif
        case (fsm_q)
            S_IDLE: begin
                if (hit_s && !break_in_prog) begin
                    fsm_d    = S_WAIT;
                    win_d    = pick_s;
                    addr_d   = pick_addr_s;
                    dout_d   = pick_data_s;
                    to_mem_d = pick_wr_s;
                    db_d     = 1'b1;
                end else begin
                    fsm_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (state == DB1_STATE) begin
                    db_d  = 1'b0;
                    fsm_d = S_XFER;
                end
`ifdef DB_WATCHDOG_EN
                else if (tmo_hit_s) begin
                    fsm_d = S_IDLE;
                    db_d  = 1'b0;
                    tmo_d = 1'b1;
                    rr_d  = next_ptr(win_q);
                end
`endif
                else begin
                    fsm_d = S_WAIT;
                end
            end
            S_XFER: begin
                if (state == DB2_STATE) begin
                    rd_d          = to_mem_q ? rd_q : dmaDIN;
                    gnt_d[win_q]  = 1'b1;
                    fsm_d         = S_ACK;
                end
`ifdef DB_WATCHDOG_EN
                else if (tmo_hit_s) begin
                    fsm_d = S_IDLE;
                    db_d  = 1'b0;
                    tmo_d = 1'b1;
                    rr_d  = next_ptr(win_q);
                end
`endif
                else begin
                    fsm_d = S_XFER;
                end
            end
            S_ACK: begin
                rr_d  = next_ptr(win_q);
                fsm_d = S_IDLE;
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase

        // Clear drops any transfer in flight but leaves the sticky error alone.
        if (clear) begin
            fsm_d    = S_IDLE;
            win_d    = '0;
            rr_d     = '0;
            db_d     = 1'b0;
            to_mem_d = 1'b0;
            addr_d   = '0;
            dout_d   = '0;
            rd_d     = '0;
            gnt_d    = '0;
        end else begin
            fsm_d = fsm_d;
        end

`ifdef DB_WATCHDOG_EN
        cnt_d = ((fsm_d == fsm_q) && ((fsm_q == S_WAIT) || (fsm_q == S_XFER))) ? cnt_q + TW'(1) : '0;
`endif
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q    <= S_IDLE;
            win_q    <= '0;
            rr_q     <= '0;
            db_q     <= 1'b0;
            to_mem_q <= 1'b0;
            addr_q   <= '0;
            dout_q   <= '0;
            rd_q     <= '0;
            gnt_q    <= '0;
`ifdef DB_WATCHDOG_EN
            cnt_q    <= '0;
            tmo_q    <= 1'b0;
`endif
        end else begin
            fsm_q    <= fsm_d;
            win_q    <= win_d;
            rr_q     <= rr_d;
            db_q     <= db_d;
            to_mem_q <= to_mem_d;
            addr_q   <= addr_d;
            dout_q   <= dout_d;
            rd_q     <= rd_d;
            gnt_q    <= gnt_d;
`ifdef DB_WATCHDOG_EN
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
`endif
        end
    end

    assign gnt        = gnt_q;
    assign rd_data    = rd_q;
    assign data_break = db_q;
    assign to_mem     = to_mem_q;
    assign dmaAddr    = addr_q;
    assign dmaDOUT    = dout_q;
`ifdef DB_WATCHDOG_EN
    assign tmo_err    = tmo_q;
`else
    assign tmo_err    = 1'b0;
`endif

endmodule

// File: tb/tb_data_break_arbiter.sv
// Randomized self-checking bench for data_break_arbiter against a transaction-level model.
// With DB_WATCHDOG_EN defined the DUT is built with DB_TMO = 16 and the timeout path is exercised.
module tb_data_break_arbiter;
    localparam int         N        = 4;
    localparam int         TMO      = 16;
    localparam logic [4:0] DB1      = 5'b10100;
    localparam logic [4:0] DB2      = 5'b10101;
    localparam logic [4:0] ST_FETCH = 5'b00000;

    logic             clk = 1'b0;
    logic             reset, clear, bip;
    logic [4:0]       state;
    logic [N-1:0]     req, req_wr;
    logic [15*N-1:0]  req_addr;
    logic [12*N-1:0]  req_data;
    logic [N-1:0]     gnt;
    logic [11:0]      rd_data, dmaDOUT, dmaDIN;
    logic             data_break, to_mem, tmo_err;
    logic [14:0]      dmaAddr;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: round-robin pointer, winner, latched transfer, read buffer, error flag.
    int          rr_m, w_m;
    logic [14:0] addr_m [N];
    logic [11:0] data_m [N];
    logic [14:0] exp_addr;
    logic [11:0] exp_dout, rd_m;
    logic        exp_wr, tmo_m;

    data_break_arbiter #(
        .N_REQ     (N),
`ifdef DB_WATCHDOG_EN
        .DB_TMO    (TMO),
`endif
        .DB1_STATE (DB1),
        .DB2_STATE (DB2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .state         (state),
        .break_in_prog (bip),
        .req           (req),
        .req_wr        (req_wr),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .gnt           (gnt),
        .rd_data       (rd_data),
        .data_break    (data_break),
        .to_mem        (to_mem),
        .dmaAddr       (dmaAddr),
        .dmaDOUT       (dmaDOUT),
        .dmaDIN        (dmaDIN),
        .tmo_err       (tmo_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_fields();
        for (int i = 0; i < N; i++) begin
            req_addr[i*15 +: 15] = addr_m[i];
            req_data[i*12 +: 12] = data_m[i];
        end
    endtask

    task automatic randomize_fields();
        for (int i = 0; i < N; i++) begin
            addr_m[i] = 15'($urandom);
            data_m[i] = 12'($urandom);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_db"},   data_break, 0);
        check_val({tag, "_gnt"},  gnt, 0);
        check_val({tag, "_tm"},   to_mem, 0);
        check_val({tag, "_addr"}, dmaAddr, 0);
        check_val({tag, "_dout"}, dmaDOUT, 0);
        check_val({tag, "_rd"},   rd_data, 0);
        check_val({tag, "_tmo"},  tmo_err, 32'(tmo_m));
    endtask

    // Present a request set; the model picks the first requester at or above rr_m, wrapping.
    task automatic launch(input logic [N-1:0] r, input logic [N-1:0] wr);
        req    = r;
        req_wr = wr;
        drive_fields();
        w_m = -1;
        for (int k = 0; k < N; k++) begin
            if (w_m < 0 && r[(rr_m + k) % N]) w_m = (rr_m + k) % N;
        end
        exp_addr = addr_m[w_m];
        exp_dout = data_m[w_m];
        exp_wr   = wr[w_m];
        tick();
        check_val("launch_db",   data_break, 1);
        check_val("launch_addr", dmaAddr, exp_addr);
        check_val("launch_dout", dmaDOUT, exp_dout);
        check_val("launch_dir",  to_mem, exp_wr);
        check_val("launch_gnt",  gnt, 0);
        check_val("launch_tmo",  tmo_err, 32'(tmo_m));
    endtask

    // Walk the CPU through DB1/DB2 and check the grant and read data.
    task automatic finish(input int hold, input int gap, input bit scramble, input bit drop,
                          input logic [11:0] din, input bit keep);
        for (int h = 0; h < hold; h++) begin
            if (scramble) begin
                randomize_fields();
                req_wr = N'($urandom);
                drive_fields();
            end
            if (drop) req = '0;
            tick();
            check_val("wait_db",   data_break, 1);
            check_val("wait_addr", dmaAddr, exp_addr);
            check_val("wait_dout", dmaDOUT, exp_dout);
            check_val("wait_dir",  to_mem, exp_wr);
        end
        state = DB1;
        tick();
        state = ST_FETCH;
        check_val("db1_drop", data_break, 0);
        check_val("db1_addr", dmaAddr, exp_addr);
        for (int g = 0; g < gap; g++) begin
            tick();
            check_val("xfer_gnt", gnt, 0);
        end
        state  = DB2;
        dmaDIN = din;
        if (!exp_wr) rd_m = din;
        tick();
        state = ST_FETCH;
        check_val("gnt_pulse", gnt, 32'(1) << w_m);
        check_val("rd_data",   rd_data, rd_m);
        check_val("gnt_db",    data_break, 0);
        if (!keep) req = '0;
        tick();
        check_val("gnt_clear", gnt, 0);
        rr_m = (w_m + 1) % N;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; clear = 1'b0; bip = 1'b0; state = ST_FETCH;
        req = '0; req_wr = '0; req_addr = '0; req_data = '0; dmaDIN = '0;
        rr_m = 0; rd_m = '0; tmo_m = 1'b0;
        for (int i = 0; i < N; i++) begin addr_m[i] = '0; data_m[i] = '0; end
        repeat (2) tick();
        check_idle_outputs("reset");
        reset = 1'b0;
        tick();

        // DB1 seen in IDLE is ignored.
        state = DB1;
        tick();
        state = ST_FETCH;
        check_val("idle_db1_db",  data_break, 0);
        check_val("idle_db1_gnt", gnt, 0);

        // Single write from requester 0.
        randomize_fields();
        addr_m[0] = 15'o10200;
        data_m[0] = 12'o1234;
        launch(4'b0001, 4'b0001);
        check_val("t1_addr", dmaAddr, 15'o10200);
        check_val("t1_dout", dmaDOUT, 12'o1234);
        finish(1, 0, 1'b0, 1'b0, 12'o0707, 1'b0);

        // All four requesting, held through the handshake: rotation 1,2,3,0,1.
        for (int n = 0; n < 5; n++) begin
            randomize_fields();
            launch(4'b1111, N'($urandom));
            check_val("rr_order", dut.gnt | (N'(1) << w_m), N'(1) << ((n + 1) % N));
            finish(0, 0, 1'b0, 1'b0, 12'($urandom), 1'b1);
        end
        req = '0;
        tick();

        // Read from requester 2.
        randomize_fields();
        launch(4'b0100, 4'b0000);
        finish(1, 1, 1'b0, 1'b0, 12'o7070, 1'b0);
        check_val("t3_rd", rd_data, 12'o7070);

        // break_in_prog blocks a new arbitration.
        randomize_fields();
        bip    = 1'b1;
        req    = 4'b0010;
        req_wr = 4'b0000;
        drive_fields();
        for (int c = 0; c < 3; c++) begin
            tick();
            check_val("bip_block", data_break, 0);
        end
        bip = 1'b0;
        launch(4'b0010, 4'b0000);
        finish(0, 0, 1'b0, 1'b0, 12'($urandom), 1'b0);

        // Clear during WAIT drops the transfer and resets the pointer.
        randomize_fields();
        launch(4'b1000, 4'b1000);
        clear = 1'b1;
        req   = '0;
        tick();
        clear = 1'b0;
        rr_m  = 0;
        rd_m  = '0;
        check_idle_outputs("clear");
        state = DB1; tick();
        check_val("clr_gnt_a", gnt, 0);
        state = DB2; tick();
        check_val("clr_gnt_b", gnt, 0);
        state = ST_FETCH; tick();
        check_val("clr_gnt_c", gnt, 0);
        randomize_fields();
        launch(4'b1111, 4'b0000);
        finish(0, 0, 1'b0, 1'b0, 12'($urandom), 1'b0);

        // Random traffic.
        for (int n = 0; n < 40; n++) begin
            randomize_fields();
            launch(N'($urandom_range(1, (1 << N) - 1)), N'($urandom));
            finish(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 12'($urandom), 1'b0);
        end

`ifdef DB_WATCHDOG_EN
        // DB1 never arrives: watchdog aborts after TMO cycles.
        randomize_fields();
        launch(4'b0100, 4'b0000);
        for (int c = 0; c < TMO - 1; c++) begin
            req = '0;
            tick();
            check_val("wd_hold", data_break, 1);
        end
        tick();
        tmo_m = 1'b1;
        rr_m  = (w_m + 1) % N;
        check_val("wd_db",  data_break, 0);
        check_val("wd_tmo", tmo_err, 1);
        check_val("wd_gnt", gnt, 0);
        tick();
        check_val("wd_gnt2", gnt, 0);
        randomize_fields();
        launch(4'b1111, 4'b1111);
        finish(0, 0, 1'b0, 1'b0, 12'($urandom), 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        rr_m  = 0;
        rd_m  = '0;
        check_idle_outputs("wd_clear");
`endif

        // Async reset in XFER zeroes outputs before the next edge.
        randomize_fields();
        launch(4'b0001, 4'b0000);
        finish(0, 0, 1'b0, 1'b0, 12'o5555, 1'b0);
        randomize_fields();
        launch(4'b0110, 4'b0110);
        state = DB1;
        tick();
        state = ST_FETCH;
        #2;
        reset = 1'b1;
        #1;
        rd_m  = '0;
        tmo_m = 1'b0;
        rr_m  = 0;
        req   = '0;
        check_idle_outputs("async_rst");
        tick();
        reset = 1'b0;
        tick();
        check_idle_outputs("post_rst");
        randomize_fields();
        launch(4'b1010, 4'b0000);
        finish(1, 1, 1'b0, 1'b0, 12'($urandom), 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
